// File: rtl/axi_fifo_pkg.sv
// Shared definitions for axi_fifo_ext: stored-word layout, output pipeline latency
// and pointer-width helpers.
package axi_fifo_pkg;

  // Stored word is {tlast, tuser, tdata} with tdata in the low bits.
  localparam int TDATA_LSB = 0;

  // Cycles from input handshake to output valid on an empty, unstalled FIFO.
  localparam int PIPE_LATENCY = 3;

  localparam int OUT_STAGES = 2;

  // Pointers carry one wrap bit above the RAM address.
  localparam int PTR_WRAP_BITS = 1;

  function automatic int tuser_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int tlast_bit(input int data_width, input int tuser_width);
    return data_width + tuser_width;
  endfunction

  function automatic int word_width(input int data_width, input int tuser_width);
    return data_width + tuser_width + 1;
  endfunction

  function automatic int ptr_width(input int addr_width);
    return addr_width + PTR_WRAP_BITS;
  endfunction

endpackage

// File: rtl/axi_fifo_ram.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
module axi_fifo_ram
  import axi_fifo_pkg::*;
#(
  parameter int WIDTH      = 41,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axi_fifo_ext.sv
// axi_fifo_ext: AXI-Stream FIFO with a two-stage output pipeline and registered fill flags.
// Define AXI_FIFO_EXT_PKT_MODE_EN to hold data until a whole packet (tlast) is stored.
module axi_fifo_ext
  import axi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int TUSER_WIDTH         = 8,
  parameter int ADDR_WIDTH          = 8,
  parameter int ALMOST_FULL_THRESH  = 16,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                    clk,
  input  logic                    sync_reset,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic [ADDR_WIDTH+1:0]   data_count,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ADDR_WIDTH:0]     pkt_count
);

  localparam int WW        = word_width(DATA_WIDTH, TUSER_WIDTH);
  localparam int PW        = ptr_width(ADDR_WIDTH);
  localparam int CW        = ADDR_WIDTH + 2;
  localparam int TUSER_LSB = tuser_lsb(DATA_WIDTH);
  localparam int TLAST_BIT = tlast_bit(DATA_WIDTH, TUSER_WIDTH);

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, ram_level_nxt;
  logic          full, empty, wr_en, rd_en, adv, read_permit;
  logic [1:0]    occ, occ_nxt;
  logic [WW-1:0] d0, d1, d0_nxt, d1_nxt, wr_word, rd_word;
  logic [CW-1:0] count_nxt;

  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign s_axis_tready = ~full;
  assign wr_en         = s_axis_tvalid & ~full;
  assign adv           = m_axis_tready | ~occ[1];
  // Only pull from RAM when d0 will have somewhere to go this cycle.
  assign rd_en         = ~empty & read_permit & ((occ != 2'b11) | m_axis_tready);

  assign wr_ptr_nxt = wr_ptr + {{(PW-1){1'b0}}, wr_en};
  assign rd_ptr_nxt = rd_ptr + {{(PW-1){1'b0}}, rd_en};

  always_comb begin
    wr_word = '0;
    wr_word[TDATA_LSB +: DATA_WIDTH]  = s_axis_tdata;
    wr_word[TUSER_LSB +: TUSER_WIDTH] = s_axis_tuser;
    wr_word[TLAST_BIT]                = s_axis_tlast;
  end

  axi_fifo_ram #(
    .WIDTH      (WW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_word),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (rd_word)
  );

  // d1 drives the output; a stalled d1 holds while d0 may still fill behind it.
  always_comb begin
    occ_nxt = occ;
    d0_nxt  = d0;
    d1_nxt  = d1;
    if (adv) begin
      d1_nxt     = d0;
      occ_nxt[1] = occ[0];
      occ_nxt[0] = rd_en;
      if (rd_en) begin
        d0_nxt = rd_word;
      end
    end else if (rd_en) begin
      d0_nxt     = rd_word;
      occ_nxt[0] = 1'b1;
    end
  end

  assign ram_level_nxt = wr_ptr_nxt - rd_ptr_nxt;
  assign count_nxt     = {1'b0, ram_level_nxt}
                       + {{(CW-1){1'b0}}, occ_nxt[0]}
                       + {{(CW-1){1'b0}}, occ_nxt[1]};

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      d0           <= '0;
      d1           <= '0;
      data_count   <= '0;
      almost_full  <= (ALMOST_FULL_THRESH <= 0);
      almost_empty <= (ALMOST_EMPTY_THRESH >= 0);
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      occ          <= occ_nxt;
      d0           <= d0_nxt;
      d1           <= d1_nxt;
      data_count   <= count_nxt;
      // Flags are derived from the registered count, hence one cycle behind it.
      almost_full  <= (int'(data_count) >= ALMOST_FULL_THRESH);
      almost_empty <= (int'(data_count) <= ALMOST_EMPTY_THRESH);
    end
  end

  assign m_axis_tvalid = occ[1];
  assign m_axis_tdata  = d1[TDATA_LSB +: DATA_WIDTH];
  assign m_axis_tuser  = d1[TUSER_LSB +: TUSER_WIDTH];
  assign m_axis_tlast  = d1[TLAST_BIT];

`ifdef AXI_FIFO_EXT_PKT_MODE_EN
  localparam logic [ADDR_WIDTH:0] PKT_ONE = 1;

  logic [ADDR_WIDTH:0] pkt_cnt;
  logic                pkt_in, pkt_out;

  assign pkt_in  = wr_en & s_axis_tlast;
  assign pkt_out = rd_en & rd_word[TLAST_BIT];
  // A packet larger than the RAM would never see its tlast stored; releasing on
  // full with no complete packet lets it fall through as cut-through.
  assign read_permit = (pkt_cnt != '0) | full;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pkt_cnt <= '0;
    end else if (pkt_in & ~pkt_out) begin
      pkt_cnt <= pkt_cnt + PKT_ONE;
    end else if (pkt_out & ~pkt_in) begin
      pkt_cnt <= pkt_cnt - PKT_ONE;
    end
  end

  assign pkt_count = pkt_cnt;
`else
  assign read_permit = 1'b1;
  assign pkt_count   = '0;
`endif

endmodule

// File: tb/tb_axi_fifo_ext.sv
// Self-checking bench for axi_fifo_ext (ADDR_WIDTH=4): occupancy/order model plus directed checks.
module tb_axi_fifo_ext;

  localparam int DW    = 32;
  localparam int UW    = 8;
  localparam int AW    = 4;
  localparam int AF    = 16;
  localparam int AE    = 2;
  localparam int DEPTH = 16;
  localparam int WW    = DW + UW + 1;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] s_axis_tdata;
  logic [UW-1:0] s_axis_tuser;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [UW-1:0] m_axis_tuser;
  logic [AW+1:0] data_count;
  logic          almost_full, almost_empty;
  logic [AW:0]   pkt_count;

  always #5 clk = ~clk;

  axi_fifo_ext #(
    .DATA_WIDTH          (DW),
    .TUSER_WIDTH         (UW),
    .ADDR_WIDTH          (AW),
    .ALMOST_FULL_THRESH  (AF),
    .ALMOST_EMPTY_THRESH (AE)
  ) dut (
    .clk           (clk),
    .sync_reset    (sync_reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .data_count    (data_count),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .pkt_count     (pkt_count)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: queue of accepted words with their accept cycle; occupancy is its size.
  typedef struct {
    logic [WW-1:0] w;
    int            acc;
  } ent_t;

  ent_t          q[$];
  int            exp_dc      = 0;
  int            exp_dc_prev = 0;
  int            n_popped    = 0;
  bit            rst_seen    = 0;
  logic [WW-1:0] mout;

  always @(negedge clk) begin
    mout = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
    if (rst_seen) begin
      check("data_count", data_count, exp_dc);
      check("almost_full", almost_full, exp_dc_prev >= AF);
      check("almost_empty", almost_empty, exp_dc_prev <= AE);
`ifndef AXI_FIFO_EXT_PKT_MODE_EN
      check("pkt_count_zero", pkt_count, 0);
      check("m_tvalid_timing", m_axis_tvalid,
            (q.size() > 0) ? (q[0].acc <= cyc - 3) : 1'b0);
`endif
      if (m_axis_tvalid) begin
        if (q.size() == 0) check("m_tvalid_when_empty", m_axis_tvalid, 0);
        else               check("m_word_order", mout, q[0].w);
      end
      if (q.size() < DEPTH)      check("s_tready_room", s_axis_tready, 1);
      if (q.size() == DEPTH + 2) check("s_tready_full", s_axis_tready, 0);
    end
    if (sync_reset) begin
      q.delete();
      exp_dc      = 0;
      exp_dc_prev = 0;
      rst_seen    = 1;
    end else begin
      if (m_axis_tvalid && m_axis_tready && q.size() > 0) begin
        void'(q.pop_front());
        n_popped++;
      end
      if (s_axis_tvalid && s_axis_tready)
        q.push_back('{w: {s_axis_tlast, s_axis_tuser, s_axis_tdata}, acc: cyc});
      exp_dc_prev = exp_dc;
      exp_dc      = q.size();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] d, input logic l);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = d[7:0];
    s_axis_tlast  = l;
  endtask

  initial begin
    int          acc, t16, p0;
    logic        af1, af2;
    bit          took, done;
    logic [31:0] seq;

    sync_reset    = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) step();
    sync_reset = 1'b0;
    at_neg();
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_s_tready", s_axis_tready, 1);
    check("rst_data_count", data_count, 0);
    check("rst_almost_empty", almost_empty, 1);
    check("rst_almost_full", almost_full, 0);
    check("rst_pkt_count", pkt_count, 0);

    // Single word, latency 3
    step();
    drive(32'hA5, 1'b1);
    at_neg();
    check("t1_accept", s_axis_tready, 1);
    step();
    s_axis_tvalid = 1'b0;
    at_neg();
    check("t1_count_n1", data_count, 1);
    check("t1_valid_n1", m_axis_tvalid, 0);
    step(); at_neg();
    check("t1_valid_n2", m_axis_tvalid, 0);
    step(); at_neg();
    check("t1_valid_n3", m_axis_tvalid, 1);
    check("t1_data_n3", m_axis_tdata, 32'hA5);
    check("t1_user_n3", m_axis_tuser, 8'hA5);
    step(); at_neg();
    check("t1_valid_n4", m_axis_tvalid, 0);
    check("t1_count_n4", data_count, 0);

    // Fill with output stalled: 16 RAM + 2 stages
    m_axis_tready = 1'b0;
    acc = 0; t16 = -1; af1 = 1'bx; af2 = 1'bx;
    seq = 32'h100;
    step();
    drive(seq, 1'b1);
    for (int i = 0; i < 40; i++) begin
      at_neg();
      if (t16 >= 0 && cyc == t16 + 1) af1 = almost_full;
      if (t16 >= 0 && cyc == t16 + 2) af2 = almost_full;
      if (!s_axis_tready) break;
      acc++;
      if (acc == 16) t16 = cyc;
      step();
      seq++;
      drive(seq, 1'b1);
    end
    check("fill_accepted", acc, 18);
    check("fill_count", data_count, 18);
    check("fill_af_lag1", af1, 0);
    check("fill_af_lag2", af2, 1);
    check("fill_head", m_axis_tdata, 32'h100);

    // Full, then stream in and out for 100 cycles across pointer wrap
    took = 0;
    step();
    m_axis_tready = 1'b1;
    p0 = n_popped;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) step();
      if (took) begin
        seq++;
        drive(seq, 1'b1);
      end
      at_neg();
      took = s_axis_tvalid && s_axis_tready;
      check("stream_valid", m_axis_tvalid, 1);
      if (i > 0) check("stream_count", data_count, 17);
      if (i > 0) check("stream_tready", s_axis_tready, 1);
    end
    step();
    s_axis_tvalid = 1'b0;
    check("stream_pops", n_popped - p0, 100);
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      at_neg();
      if (data_count == 0 && !m_axis_tvalid) done = 1;
      else step();
    end
    check("drain_empty", data_count, 0);

    // Reset with 7 words held
    step();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(32'h300 + i, 1'b1);
      at_neg();
      check("hold_accept", s_axis_tready, 1);
      step();
    end
    s_axis_tvalid = 1'b0;
    sync_reset    = 1'b1;
    at_neg();
    check("hold_count", data_count, 7);
    step();
    sync_reset    = 1'b0;
    m_axis_tready = 1'b1;
    at_neg();
    check("post_rst_valid", m_axis_tvalid, 0);
    check("post_rst_count", data_count, 0);
    check("post_rst_tready", s_axis_tready, 1);
    step();
    drive(32'h77, 1'b1);
    at_neg();
    step();
    s_axis_tvalid = 1'b0;
    at_neg();
    check("post_rst_count_n1", data_count, 1);
    step(); at_neg();
    check("post_rst_valid_n2", m_axis_tvalid, 0);
    step(); at_neg();
    check("post_rst_valid_n3", m_axis_tvalid, 1);
    check("post_rst_data_n3", m_axis_tdata, 32'h77);
    step(); at_neg();
    check("post_rst_alone", m_axis_tvalid, 0);

`ifdef AXI_FIFO_EXT_PKT_MODE_EN
    // 5-word packet with 2-cycle gaps
    for (int i = 0; i < 5; i++) begin
      step();
      drive(32'hC0 + i, i == 4);
      at_neg();
      check("pkt_accept", s_axis_tready, 1);
      check("pkt_hold_valid", m_axis_tvalid, 0);
      check("pkt_count_pre", pkt_count, 0);
      step();
      s_axis_tvalid = 1'b0;
      at_neg();
      check("pkt_gap_valid", m_axis_tvalid, 0);
      if (i == 4) check("pkt_count_one", pkt_count, 1);
      step(); at_neg();
      check("pkt_gap_valid", m_axis_tvalid, 0);
      if (i == 4) check("pkt_count_one_n2", pkt_count, 1);
    end
    step(); at_neg();
    check("pkt_first_valid", m_axis_tvalid, 1);
    check("pkt_first_data", m_axis_tdata, 32'hC0);
    p0 = n_popped;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(); at_neg();
      if (!m_axis_tvalid) done = 1;
    end
    check("pkt_drained_words", n_popped - p0, 5);
    check("pkt_count_zero_end", pkt_count, 0);

    // 40-word packet larger than the RAM
    step();
    p0 = n_popped;
    for (int i = 0; i < 40; i++) begin
      drive(32'h200 + i, i == 39);
      done = 0;
      for (int k = 0; k < 50 && !done; k++) begin
        at_neg();
        if (s_axis_tready) begin
          done = 1;
          if (i < 16) check("big_hold_valid", m_axis_tvalid, 0);
        end
        step();
      end
      if (!done) check("big_accept_timeout", s_axis_tready, 1);
    end
    s_axis_tvalid = 1'b0;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      at_neg();
      if (n_popped - p0 >= 40) done = 1;
      step();
    end
    check("big_words_out", n_popped - p0, 40);
    at_neg();
    check("big_pkt_count_end", pkt_count, 0);
    check("big_count_end", data_count, 0);
`endif

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
